// File: rtl/immediate_compressor.sv
// immediate_compressor: finds the narrowest sign-extended immediate field
// (4, 8 or 11 bits) that reproduces a WIDTH-bit signed value.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-low reset
//   InValid    in   In is valid
//   InReady    out  block can accept (IDLE only)
//   In         in   [WIDTH-1:0] signed value to compress
//   OutValid   out  result valid, held until OutReady
//   OutReady   in   consumer takes result
//   Out        out  [10:0] field bits, zero above the chosen field
//   Size       out  [1:0] 0=4b, 1=8b, 2=11b, 3=fits none
//   Fits       out  1 when Size != 3
//   Overflows  out  [7:0] saturating count of Size==3 results
module immediate_compressor #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [10:0]      Out,
    output logic [1:0]       Size,
    output logic             Fits,
    output logic [7:0]       Overflows
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK4  = 3'd1,
        CHECK8  = 3'd2,
        CHECK11 = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [10:0]      out_q, out_d;
    logic [1:0]       size_q, size_d;
    logic             fits_q, fits_d;
    logic [7:0]       ovf_q, ovf_d;

    // A field of n bits fits when every bit from n-1 upward
    // equals the field's sign bit.
    logic fit4, fit8, fit11;

    assign fit4  = (hold_q[WIDTH-1:3]  == {(WIDTH-3){hold_q[3]}});
    assign fit8  = (hold_q[WIDTH-1:7]  == {(WIDTH-7){hold_q[7]}});
    assign fit11 = (hold_q[WIDTH-1:10] == {(WIDTH-10){hold_q[10]}});

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            out_q   <= '0;
            size_q  <= '0;
            fits_q  <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            size_q  <= size_d;
            fits_q  <= fits_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        out_d   = out_q;
        size_d  = size_q;
        fits_d  = fits_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    hold_d  = In;
                    state_d = CHECK4;
                end
            end
            CHECK4: begin
                if (fit4) begin
                    out_d   = {7'b0, hold_q[3:0]};
                    size_d  = 2'd0;
                    fits_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = CHECK8;
                end
            end
            CHECK8: begin
                if (fit8) begin
                    out_d   = {3'b0, hold_q[7:0]};
                    size_d  = 2'd1;
                    fits_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = CHECK11;
                end
            end
            CHECK11: begin
                out_d   = hold_q[10:0];
                state_d = DONE;
                if (fit11) begin
                    size_d = 2'd2;
                    fits_d = 1'b1;
                end else begin
                    size_d = 2'd3;
                    fits_d = 1'b0;
                    if (ovf_q != 8'hFF) begin
                        ovf_d = ovf_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign InReady   = (state_q == IDLE);
    assign OutValid  = (state_q == DONE);
    assign Out       = out_q;
    assign Size      = size_q;
    assign Fits      = fits_q;
    assign Overflows = ovf_q;

endmodule

// File: tb/tb_immediate_compressor.sv
// tb_immediate_compressor: table vectors, scoreboard, backpressure,
// mid-operation reset and a boundary/random sweep.
module tb_immediate_compressor;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [15:0] In;
    logic        OutValid;
    logic        OutReady;
    logic [10:0] Out;
    logic [1:0]  Size;
    logic        Fits;
    logic [7:0]  Overflows;

    immediate_compressor #(.WIDTH(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .In       (In),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Out      (Out),
        .Size     (Size),
        .Fits     (Fits),
        .Overflows(Overflows)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] in;
        logic [10:0] out;
        logic [1:0]  size;
        logic        fits;
    } vec_t;

    typedef struct {
        logic [15:0] in;
        logic [10:0] out;
        logic [1:0]  size;
        logic        fits;
        logic [7:0]  ovf;
        int          lat;
    } exp_t;

    vec_t tbl[12];
    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   ovf_m = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: classify by signed range rather than bit patterns.
    task automatic push_exp(input logic [15:0] v, output exp_t e);
        int s;
        s = int'($signed(v));
        e.in = v;
        if (s >= -8 && s <= 7) begin
            e.size = 2'd0;
            e.out  = {7'b0, v[3:0]};
        end else if (s >= -128 && s <= 127) begin
            e.size = 2'd1;
            e.out  = {3'b0, v[7:0]};
        end else if (s >= -1024 && s <= 1023) begin
            e.size = 2'd2;
            e.out  = v[10:0];
        end else begin
            e.size = 2'd3;
            e.out  = v[10:0];
            if (ovf_m < 255) ovf_m++;
        end
        e.fits = (e.size != 2'd3);
        e.ovf  = 8'(ovf_m);
        e.lat  = (e.size == 2'd3) ? 3 : int'(e.size) + 1;
        sbq.push_back(e);
    endtask

    always @(negedge Clock) begin
        exp_t        e;
        logic [15:0] ext;
        if (Reset && OutValid && OutReady) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_out", Out, e.out);
                chk("sb_size", Size, e.size);
                chk("sb_fits", Fits, e.fits);
                chk("sb_ovf", Overflows, e.ovf);
                if (Fits) begin
                    case (Size)
                        2'd0:    ext = {{12{Out[3]}}, Out[3:0]};
                        2'd1:    ext = {{8{Out[7]}}, Out[7:0]};
                        default: ext = {{5{Out[10]}}, Out[10:0]};
                    endcase
                    chk("roundtrip", ext, e.in);
                end
            end
        end
    end

    task automatic send(input logic [15:0] v);
        exp_t e;
        int   n;
        int   lat;
        n = 0;
        while (!InReady && n < 20) begin
            @(posedge Clock); #1;
            n++;
        end
        if (!InReady) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        push_exp(v, e);
        In = v;
        InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        lat = 0;
        do begin
            @(posedge Clock); #1;
            lat++;
        end while (!OutValid && lat < 10);
        chk("latency", lat, e.lat);
        if (OutReady) begin
            @(posedge Clock); #1;
            chk("reready", InReady, 1);
        end
    endtask

    initial begin
        exp_t e;
        int   seen;
        tbl[0]  = '{16'h0007, 11'h007, 2'd0, 1'b1};
        tbl[1]  = '{16'hFFF8, 11'h008, 2'd0, 1'b1};
        tbl[2]  = '{16'h0008, 11'h008, 2'd1, 1'b1};
        tbl[3]  = '{16'hFFF7, 11'h0F7, 2'd1, 1'b1};
        tbl[4]  = '{16'hFF80, 11'h080, 2'd1, 1'b1};
        tbl[5]  = '{16'h007F, 11'h07F, 2'd1, 1'b1};
        tbl[6]  = '{16'h03FF, 11'h3FF, 2'd2, 1'b1};
        tbl[7]  = '{16'hFC00, 11'h400, 2'd2, 1'b1};
        tbl[8]  = '{16'h0400, 11'h400, 2'd3, 1'b0};
        tbl[9]  = '{16'hFBFF, 11'h3FF, 2'd3, 1'b0};
        tbl[10] = '{16'h0080, 11'h080, 2'd2, 1'b1};
        tbl[11] = '{16'hFF7F, 11'h77F, 2'd2, 1'b1};

        Reset    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        In       = 16'h0;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_inready", InReady, 1);
        chk("rst_outvalid", OutValid, 0);
        chk("rst_out", Out, 0);
        chk("rst_size", Size, 0);
        chk("rst_fits", Fits, 0);
        chk("rst_ovf", Overflows, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].in);
            chk("tbl_out", Out, tbl[i].out);
            chk("tbl_size", Size, tbl[i].size);
            chk("tbl_fits", Fits, tbl[i].fits);
        end
        chk("ovf_after_tbl", Overflows, 2);

        for (int i = 0; i < 300; i++) send(16'h8000);
        chk("ovf_saturate", Overflows, 255);

        OutReady = 1'b0;
        push_exp(16'h0005, e);
        In = 16'h0005;
        InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        @(posedge Clock); #1;
        chk("bp_latency1", OutValid, 1);
        for (int i = 0; i < 5; i++) begin
            InValid = i[0];
            In = 16'h0100;
            @(posedge Clock); #1;
            chk("bp_outvalid", OutValid, 1);
            chk("bp_out", Out, 11'h005);
            chk("bp_size", Size, 0);
            chk("bp_inready", InReady, 0);
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock); #1;
        chk("bp_release_inready", InReady, 1);
        chk("bp_release_outvalid", OutValid, 0);

        In = 16'h0100;
        InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        @(posedge Clock); #1;
        #2;
        Reset = 1'b0;
        #1;
        sbq.delete();
        ovf_m = 0;
        chk("mid_rst_outvalid", OutValid, 0);
        chk("mid_rst_inready", InReady, 1);
        chk("mid_rst_out", Out, 0);
        chk("mid_rst_size", Size, 0);
        chk("mid_rst_ovf", Overflows, 0);
        @(posedge Clock); #2;
        Reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge Clock); #1;
            if (OutValid) seen++;
        end
        chk("no_result_after_rst", seen, 0);

        for (int s = -1100; s <= 1100; s++) send(16'(s));
        for (int i = 0; i < 1000; i++) send(16'($urandom));

        chk("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
